// File: rtl/game_pkg.sv
// Shared definitions for the reaction game: judge states, key count, LFSR taps
// and the default timing constants also used by the display and timer blocks.
package game_pkg;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    ARMED        = 2'd1,
    PENALTY      = 2'd2,
    DONE         = 2'd3
  } judge_state_e;

  localparam int          KEY_COUNT           = 4;
  localparam logic [7:0]  LFSR_TAPS           = 8'b1011_1000; // l[7]^l[5]^l[4]^l[3]
  localparam int          DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int          PENALTY_CYCLES_DEF  = 25_000_000;
  localparam logic [7:0]  LFSR_SEED_DEF       = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_match_judge_if.sv
// Player-facing signals of the key judge: raw keys and game state in,
// target index and judgement pulses out.
interface key_match_judge_if;
  import game_pkg::*;

  logic [KEY_COUNT-1:0] key_n;
  logic                 game_ended;
  logic [1:0]           target;
  logic                 correct;
  logic                 wrong;
  logic                 locked;

  modport master (output key_n, game_ended, input target, correct, wrong, locked);
  modport slave  (input key_n, game_ended, output target, correct, wrong, locked);

endinterface

// File: rtl/key_debouncer.sv
// One key: two-flop synchronizer, saturating stability counter and accepted
// (pressed = 1) level. idle_o flags a release that has been confirmed stable.
module key_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic level_o,
  output logic idle_o
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          samp_q, samp_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  always_comb begin
    sync_d  = {sync_q[0], key_n_i};
    pressed = ~sync_q[1];
    samp_d  = pressed;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (pressed != samp_q)   cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    // cnt_q == CNT_MAX means samp_q has been seen DEBOUNCE_CYCLES times in a row
    if (cnt_q == CNT_MAX)    level_d = samp_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= 2'b11;
      samp_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      samp_q  <= samp_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign idle_o  = ~level_q & ~samp_q & (cnt_q == CNT_MAX);

endmodule

// File: rtl/key_match_judge.sv
// Debounces the four keys, judges each press against the LFSR target and
// emits registered correct/wrong pulses with a lock-out after a miss.
module key_match_judge
  import game_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int         PENALTY_CYCLES  = PENALTY_CYCLES_DEF,
  parameter logic [7:0] LFSR_SEED       = LFSR_SEED_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  key_match_judge_if.slave   bus
);

  localparam int PW = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;

  logic [KEY_COUNT-1:0] level, idle, events, tgt_onehot;
  logic [KEY_COUNT-1:0] prev_q, prev_d;
  judge_state_e         state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [PW-1:0]        pen_q, pen_d;
  logic                 correct_q, correct_d, wrong_q, wrong_d, locked_q, locked_d;
  logic                 match, miss;

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_deb
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .resetn  (resetn),
      .key_n_i (bus.key_n[k]),
      .level_o (level[k]),
      .idle_o  (idle[k])
    );
  end

  assign events     = level & ~prev_q;
  assign tgt_onehot = KEY_COUNT'(1) << lfsr_q[1:0];
  assign match      = (events == tgt_onehot);
  assign miss       = (events != '0) && !match;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pen_d     = pen_q;
    prev_d    = level;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    locked_d  = locked_q;
    if (bus.game_ended) begin
      state_d  = DONE;
      locked_d = 1'b1;
    end else begin
      unique case (state_q)
        // Arm only on a confirmed release so a key held through reset never scores
        WAIT_RELEASE: if (&idle) state_d = ARMED;
        ARMED: begin
          // A press right behind a hit is dropped to keep pulses non-adjacent
          if (!correct_q) begin
            if (match) begin
              correct_d = 1'b1;
              lfsr_d    = lfsr_step(lfsr_q);
            end else if (miss) begin
              wrong_d  = 1'b1;
              locked_d = 1'b1;
              pen_d    = PW'(PENALTY_CYCLES - 1);
              state_d  = PENALTY;
            end
          end
        end
        PENALTY: begin
          if (pen_q == '0) begin
            locked_d = 1'b0;
            state_d  = WAIT_RELEASE;
          end else begin
            pen_d = pen_q - 1'b1;
          end
        end
        DONE: locked_d = 1'b1;
        default: state_d = WAIT_RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= WAIT_RELEASE;
      lfsr_q    <= LFSR_SEED;
      pen_q     <= '0;
      prev_q    <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pen_q     <= pen_d;
      prev_q    <= prev_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.target  = lfsr_q[1:0];
  assign bus.correct = correct_q;
  assign bus.wrong   = wrong_q;
  assign bus.locked  = locked_q;

endmodule

// File: tb/tb_key_match_judge.sv
// Directed bench for key_match_judge with short debounce/penalty windows.
module tb_key_match_judge;
  import game_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  key_match_judge_if bus();

  key_match_judge #(
    .DEBOUNCE_CYCLES(4),
    .PENALTY_CYCLES (8),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   vectors = 0, miscompares = 0;
  int   step_idx, n_cor, n_wr, n_lock, n_bad, first_cor, first_wr;
  logic prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    step_idx++;
    if (bus.correct === 1'b1) begin
      n_cor++;
      if (first_cor < 0) first_cor = step_idx;
    end
    if (bus.wrong === 1'b1) begin
      n_wr++;
      if (first_wr < 0) first_wr = step_idx;
    end
    if (bus.locked === 1'b1) n_lock++;
    if ((bus.correct && bus.wrong) || ((bus.correct || bus.wrong) && prev_pulse)) n_bad++;
    prev_pulse = bus.correct | bus.wrong;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear();
    step_idx = 0; n_cor = 0; n_wr = 0; n_lock = 0;
    first_cor = -1; first_wr = -1;
  endtask

  initial begin
    bus.key_n      = 4'hF;
    bus.game_ended = 1'b0;
    clear();
    n_bad = 0;
    run(3);
    check("rst_target",  bus.target,  2'b01);
    check("rst_correct", bus.correct, 1'b0);
    check("rst_wrong",   bus.wrong,   1'b0);
    check("rst_locked",  bus.locked,  1'b0);

    // 1: key 1 matches target 01
    resetn = 1'b1;
    run(6);
    clear();
    bus.key_n = 4'b1101; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t1_correct_cnt", n_cor, 1);
    check("t1_latency",     first_cor, 8);
    check("t1_wrong_cnt",   n_wr, 0);
    check("t1_target",      bus.target, 2'b10);

    // 2: key 3 misses, key 2 during lock-out ignored, then key 2 scores
    clear();
    bus.key_n = 4'b0111; run(6);
    bus.key_n = 4'b1011; run(6);
    bus.key_n = 4'hF;    run(12);
    check("t2_wrong_cnt",   n_wr, 1);
    check("t2_wrong_lat",   first_wr, 8);
    check("t2_correct_cnt", n_cor, 0);
    check("t2_locked_len",  n_lock, 8);
    clear();
    bus.key_n = 4'b1011; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t2_retry_correct", n_cor, 1);
    check("t2_retry_lat",     first_cor, 8);
    check("t2_target",        bus.target, 2'b01);

    // 3: bouncing key 2, then held: one judged event (a miss, target 01)
    clear();
    for (int i = 0; i < 10; i++) begin
      bus.key_n = (i % 2 == 0) ? 4'b1011 : 4'hF;
      run(2);
    end
    bus.key_n = 4'b1011; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t3_wrong_cnt",   n_wr, 1);
    check("t3_wrong_lat",   first_wr, 28);
    check("t3_correct_cnt", n_cor, 0);
    check("t3_target",      bus.target, 2'b01);

    // 4: keys 1+2 together with target 01 is a miss
    clear();
    bus.key_n = 4'b1001; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t4_wrong_cnt",   n_wr, 1);
    check("t4_correct_cnt", n_cor, 0);

    // 5: key 1 held through reset must not score until re-pressed
    bus.key_n = 4'b1101;
    resetn = 1'b0; run(3);
    check("t5_rst_target", bus.target, 2'b01);
    resetn = 1'b1;
    clear();
    run(12);
    bus.key_n = 4'hF; run(12);
    check("t5_held_correct", n_cor, 0);
    check("t5_held_wrong",   n_wr, 0);
    clear();
    bus.key_n = 4'b1101; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t5_repress_correct", n_cor, 1);
    check("t5_repress_lat",     first_cor, 8);
    check("t5_target",          bus.target, 2'b10);

    // 6: game_ended in the judging cycle of a matching key 2
    clear();
    bus.key_n = 4'b1011; run(6);
    bus.key_n = 4'hF;    run(1);
    bus.game_ended = 1'b1; run(13);
    check("t6_correct_cnt", n_cor, 0);
    check("t6_wrong_cnt",   n_wr, 0);
    check("t6_locked",      bus.locked, 1'b1);
    bus.game_ended = 1'b0;
    clear();
    bus.key_n = 4'b1101; run(6);
    bus.key_n = 4'hF;    run(14);
    check("t6_after_correct", n_cor, 0);
    check("t6_after_wrong",   n_wr, 0);
    check("t6_locked_cycles", n_lock, 20);
    resetn = 1'b0; run(1);
    check("t6_rst_target", bus.target, 2'b01);
    check("t6_rst_locked", bus.locked, 1'b0);
    check("pulse_rules",   n_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
